// File: rtl/rv32i_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer and its decoder.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    // Major opcodes of the supported RV32I classes
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Register-file write-data source select
    localparam logic [2:0] RFWD_ALU    = 3'd0;
    localparam logic [2:0] RFWD_BUS    = 3'd1;
    localparam logic [2:0] RFWD_IMM    = 3'd2;
    localparam logic [2:0] RFWD_PC_IMM = 3'd3;
    localparam logic [2:0] RFWD_PC_4   = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR
    } instr_class_e;

    typedef enum logic [1:0] {
        TRAP_NONE,
        TRAP_ILLEGAL,
        TRAP_MISALIGNED,
        TRAP_BUS_TIMEOUT
    } trap_cause_e;

    // Encoded like funct3[1:0] of loads/stores
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } access_size_e;

    typedef struct packed {
        instr_class_e cls;
        logic [3:0]   alu_control;
        logic         alu_src;
        logic         rd1_sel;
        logic [2:0]   rfwd_src;
        access_size_e acc_size;
        logic         illegal;
    } decode_t;

    // Lane enables for an access of the given size at the given low address bits
    function automatic logic [3:0] byte_enable(input access_size_e acc_size, input logic [1:0] addr_low);
        case (acc_size)
            SIZE_BYTE: return 4'b0001 << addr_low;
            SIZE_HALF: return 4'b0011 << {addr_low[1], 1'b0};
            default:   return 4'b1111;
        endcase
    endfunction

    // Halves need an even address, words a 4-byte aligned one
    function automatic logic is_misaligned(input access_size_e acc_size, input logic [1:0] addr_low);
        case (acc_size)
            SIZE_HALF: return addr_low[0];
            SIZE_WORD: return addr_low != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational instruction decoder: class, datapath selects, access size, legality.
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    output decode_t         dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    // Register specifiers and immediates are consumed by the datapath, not here
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    // Opcode/funct decode; any reserved encoding collapses to the illegal class
    always_comb begin
        dec_o             = '0;
        dec_o.cls         = CLS_ILLEGAL;
        dec_o.alu_control = 4'b0000;
        dec_o.alu_src     = 1'b0;
        dec_o.rd1_sel     = 1'b0;
        dec_o.rfwd_src    = RFWD_ALU;
        dec_o.acc_size    = SIZE_WORD;
        dec_o.illegal     = 1'b1;
        case (opcode)
            OP_R: begin
                dec_o.cls         = CLS_R;
                dec_o.alu_control = {funct7[5], funct3};
                dec_o.illegal     = !((funct7 == 7'b0000000) ||
                                      ((funct7 == 7'b0100000) &&
                                       ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OP_I_ALU: begin
                dec_o.cls         = CLS_I_ALU;
                dec_o.alu_src     = 1'b1;
                // Only SRAI carries a meaningful funct7[5]; other immediates must not flip the op
                dec_o.alu_control = {(funct3 == 3'b101) & funct7[5], funct3};
                if (funct3 == 3'b001) begin
                    dec_o.illegal = funct7 != 7'b0000000;
                end else if (funct3 == 3'b101) begin
                    dec_o.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end else begin
                    dec_o.illegal = 1'b0;
                end
            end
            OP_LOAD: begin
                dec_o.cls      = CLS_LOAD;
                dec_o.alu_src  = 1'b1;
                dec_o.rfwd_src = RFWD_BUS;
                dec_o.acc_size = access_size_e'(funct3[1:0]);
                dec_o.illegal  = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
            end
            OP_STORE: begin
                dec_o.cls      = CLS_STORE;
                dec_o.alu_src  = 1'b1;
                dec_o.acc_size = access_size_e'(funct3[1:0]);
                dec_o.illegal  = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OP_BRANCH: begin
                dec_o.cls         = CLS_BRANCH;
                dec_o.alu_control = {1'b0, funct3};
                dec_o.illegal     = funct3[2:1] == 2'b01;
            end
            OP_LUI: begin
                dec_o.cls      = CLS_LUI;
                dec_o.alu_src  = 1'b1;
                dec_o.rfwd_src = RFWD_IMM;
                dec_o.illegal  = 1'b0;
            end
            OP_AUIPC: begin
                dec_o.cls      = CLS_AUIPC;
                dec_o.alu_src  = 1'b1;
                dec_o.rd1_sel  = 1'b1;
                dec_o.rfwd_src = RFWD_PC_IMM;
                dec_o.illegal  = 1'b0;
            end
            OP_JAL: begin
                dec_o.cls      = CLS_JAL;
                dec_o.alu_src  = 1'b1;
                dec_o.rd1_sel  = 1'b1;
                dec_o.rfwd_src = RFWD_PC_4;
                dec_o.illegal  = 1'b0;
            end
            OP_JALR: begin
                dec_o.cls      = CLS_JALR;
                dec_o.alu_src  = 1'b1;
                dec_o.rfwd_src = RFWD_PC_4;
                dec_o.illegal  = funct3 != 3'b000;
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
        if (dec_o.illegal) begin
            dec_o.cls = CLS_ILLEGAL;
        end
    end

endmodule

// File: rtl/rv32i_mc_control.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB/TRAP with bus handshake.
module rv32i_mc_control
    import rv32i_pkg::*;
#(
    parameter bit          HAS_WAIT    = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instrCode,
    input  logic [1:0]      busAddrLow,
    input  logic            busReady,
    output logic            pcEn,
    output logic            irEn,
    output logic            regFileWe,
    output logic [3:0]      aluControl,
    output logic            aluSrcMuxSel,
    output logic            RD1MuxSel,
    output logic [2:0]      RFWDSrcMuxSel,
    output logic            branch,
    output logic            jump,
    output logic            busWe,
    output logic            busRe,
    output logic [3:0]      busByteEn,
    output logic            trap,
    output logic [1:0]      trapCause
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // Counter value at which one more idle MEM cycle exhausts the budget
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    trap_cause_e       cause_q, cause_d;
    logic              bus_re_q, bus_re_d;
    logic              bus_we_q, bus_we_d;
    logic [3:0]        byte_en_q, byte_en_d;

    decode_t           dec;
    logic              active;
    logic              mem_done;
    logic              timeout_hit;
    logic              exec_writes;

    rv32i_decoder u_decoder (
        .instr_i (instrCode),
        .dec_o   (dec)
    );

    assign active      = reset;
    assign mem_done    = (HAS_WAIT == 1'b0) || busReady;
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign exec_writes = (dec.cls == CLS_R)     || (dec.cls == CLS_I_ALU) ||
                         (dec.cls == CLS_LUI)   || (dec.cls == CLS_AUIPC) ||
                         (dec.cls == CLS_JAL)   || (dec.cls == CLS_JALR);

    // Next-state, wait counter, trap cause and registered bus strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        bus_re_d  = 1'b0;
        bus_we_d  = 1'b0;
        byte_en_d = 4'b0000;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec.illegal) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if ((dec.cls == CLS_LOAD) || (dec.cls == CLS_STORE)) begin
                    if (is_misaligned(dec.acc_size, busAddrLow)) begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_MISALIGNED;
                    end else begin
                        // Lane enables are captured here so they stay stable for the whole access
                        state_d   = ST_MEM;
                        cnt_d     = '0;
                        bus_re_d  = dec.cls == CLS_LOAD;
                        bus_we_d  = dec.cls == CLS_STORE;
                        byte_en_d = byte_enable(dec.acc_size, busAddrLow);
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (mem_done) begin
                    state_d = bus_re_q ? ST_WB : ST_FETCH;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_BUS_TIMEOUT;
                end else begin
                    bus_re_d  = bus_re_q;
                    bus_we_d  = bus_we_q;
                    byte_en_d = byte_en_q;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and strobe registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            cause_q   <= TRAP_NONE;
            bus_re_q  <= 1'b0;
            bus_we_q  <= 1'b0;
            byte_en_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            bus_re_q  <= bus_re_d;
            bus_we_q  <= bus_we_d;
            byte_en_q <= byte_en_d;
        end
    end

    // Decoded enables and selects; forced low while reset is held so nothing leaks out
    always_comb begin
        irEn          = active && (state_q == ST_FETCH);
        pcEn          = active && (((state_q == ST_EXECUTE) && (exec_writes || (dec.cls == CLS_BRANCH))) ||
                                   ((state_q == ST_MEM) && bus_we_q && mem_done) ||
                                   (state_q == ST_WB));
        regFileWe     = active && (((state_q == ST_EXECUTE) && exec_writes) || (state_q == ST_WB));
        branch        = active && (state_q == ST_EXECUTE) && (dec.cls == CLS_BRANCH);
        jump          = active && (state_q == ST_EXECUTE) &&
                        ((dec.cls == CLS_JAL) || (dec.cls == CLS_JALR));
        aluControl    = active ? dec.alu_control : 4'b0000;
        aluSrcMuxSel  = active && dec.alu_src;
        RD1MuxSel     = active && dec.rd1_sel;
        RFWDSrcMuxSel = !active ? 3'd0 : ((state_q == ST_WB) ? RFWD_BUS : dec.rfwd_src);
    end

    assign busWe     = bus_we_q;
    assign busRe     = bus_re_q;
    assign busByteEn = byte_en_q;
    assign trap      = state_q == ST_TRAP;
    assign trapCause = cause_q;

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Randomized bench for rv32i_mc_control against a cycle-level behavioural model.
module tb_rv32i_mc_control;

    localparam int unsigned TMO = 16;

    typedef enum int {K_ILL, K_R, K_I, K_L, K_S, K_B, K_LUI, K_AUIPC, K_JAL, K_JALR} kind_e;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr;
    logic [1:0]  addr_low;
    logic        bus_ready;

    logic        pcEn, irEn, regFileWe, aluSrcMuxSel, RD1MuxSel, branch, jump;
    logic        busWe, busRe, trap;
    logic [3:0]  aluControl, busByteEn;
    logic [2:0]  RFWDSrcMuxSel;
    logic [1:0]  trapCause;

    logic [13:0] ctl;
    logic [8:0]  sel;

    int n_cmp;
    int n_err;

    rv32i_mc_control #(.HAS_WAIT(1'b1), .MEM_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .instrCode     (instr),
        .busAddrLow    (addr_low),
        .busReady      (bus_ready),
        .pcEn          (pcEn),
        .irEn          (irEn),
        .regFileWe     (regFileWe),
        .aluControl    (aluControl),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .RD1MuxSel     (RD1MuxSel),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .branch        (branch),
        .jump          (jump),
        .busWe         (busWe),
        .busRe         (busRe),
        .busByteEn     (busByteEn),
        .trap          (trap),
        .trapCause     (trapCause)
    );

    always #5 clk = ~clk;

    assign ctl = {irEn, pcEn, regFileWe, branch, jump, busWe, busRe, busByteEn, trap, trapCause};
    assign sel = {aluControl, aluSrcMuxSel, RD1MuxSel, RFWDSrcMuxSel};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] mk_ctl(input bit ir, input bit pc, input bit rf, input bit br,
                                           input bit jp, input bit we, input bit re,
                                           input logic [3:0] be, input bit tr, input logic [1:0] cs);
        return {ir, pc, rf, br, jp, we, re, be, tr, cs};
    endfunction

    // Instruction class from the ISA's legal encodings
    function automatic kind_e kind_of(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? K_R : K_ILL;
            7'h13: begin
                if (f3 == 3'd1) return (f7 == 7'h00) ? K_I : K_ILL;
                if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? K_I : K_ILL;
                return K_I;
            end
            7'h03: return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) ? K_L : K_ILL;
            7'h23: return (f3 <= 3'd2) ? K_S : K_ILL;
            7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_B;
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            7'h6F: return K_JAL;
            7'h67: return (f3 == 3'd0) ? K_JALR : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h03;
            3: r[6:0] = 7'h23;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h37;
            6: r[6:0] = 7'h17;
            7: r[6:0] = 7'h6F;
            8: r[6:0] = 7'h67;
            default: r[6:0] = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    // One cycle: drive inputs after the edge, check at the falling edge, optionally advance
    task automatic cyc(input string tag, input logic rdy, input logic [1:0] al,
                       input logic [13:0] exp_ctl, input logic [8:0] exp_sel,
                       input logic [8:0] mask, input bit adv);
        bus_ready = rdy;
        addr_low  = al;
        @(negedge clk);
        check_eq({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        if (mask != 9'd0) check_eq({tag, ".sel"}, 32'(sel & mask), 32'(exp_sel & mask));
        if (adv) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset pulse: every output must drop immediately and stay low; released just after an edge
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, ".rst_async"}, 32'({ctl, sel}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq({tag, ".rst_hold"}, 32'({ctl, sel}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic trap_seq(input string tag, input logic [1:0] cause);
        for (int t = 0; t < 3; t++) begin
            cyc({tag, ".trap"}, 1'($urandom), 2'($urandom),
                mk_ctl(0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, cause), 9'd0, 9'd0, 1'b1);
        end
        reset_pulse(tag);
    endtask

    // Run one instruction from FETCH; w = idle MEM cycles before busReady, abort_at = MEM cycle to reset in
    task automatic run_instr(input logic [31:0] ins, input logic [1:0] addr, input int w,
                             input int abort_at, input string tag);
        kind_e       k;
        logic [2:0]  f3;
        logic [1:0]  sz;
        bit          mis, wr, is_b, jp, is_ld, is_st, rdy;
        logic [3:0]  be, a, am;
        bit          s, sm, d;
        logic [2:0]  f, fm;
        logic [13:0] ec;
        k     = kind_of(ins);
        f3    = ins[14:12];
        sz    = f3[1:0];
        is_ld = (k == K_L);
        is_st = (k == K_S);
        mis   = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr != 2'd0);
        be    = (sz == 2'd0) ? 4'(1 << addr) : (sz == 2'd1) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        instr = ins;

        cyc({tag, ".fetch"}, 1'($urandom), 2'($urandom), mk_ctl(1, 0, 0, 0, 0, 0, 0, 4'b0, 0, 2'd0), 9'd0, 9'd0, 1'b1);
        cyc({tag, ".decode"}, 1'($urandom), 2'($urandom), mk_ctl(0, 0, 0, 0, 0, 0, 0, 4'b0, 0, 2'd0), 9'd0, 9'd0, 1'b1);
        if (k == K_ILL) begin
            trap_seq(tag, 2'd1);
            return;
        end

        wr   = (k == K_R) || (k == K_I) || (k == K_LUI) || (k == K_AUIPC) || (k == K_JAL) || (k == K_JALR);
        is_b = (k == K_B);
        jp   = (k == K_JAL) || (k == K_JALR);
        ec   = mk_ctl(0, wr | is_b, wr, is_b, jp, 0, 0, 4'b0, 0, 2'd0);
        a    = 4'b0000;
        am   = 4'b0000;
        if (k == K_R) begin
            a  = {ins[30], f3};
            am = 4'b1111;
        end else if (k == K_I) begin
            a  = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
            am = 4'b1111;
        end
        s  = !((k == K_R) || (k == K_B));
        sm = (k != K_LUI);
        d  = (k == K_AUIPC) || (k == K_JAL);
        case (k)
            K_LUI:        begin f = 3'd2; fm = 3'b111; end
            K_AUIPC:      begin f = 3'd3; fm = 3'b111; end
            K_JAL, K_JALR: begin f = 3'd4; fm = 3'b111; end
            K_R, K_I:     begin f = 3'd0; fm = 3'b111; end
            default:      begin f = 3'd0; fm = 3'b000; end
        endcase
        cyc({tag, ".exec"}, 1'($urandom), addr, ec, {a, s, d, f}, {am, sm, 1'b1, fm}, 1'b1);
        if (!(is_ld || is_st)) return;
        if (mis) begin
            trap_seq(tag, 2'd2);
            return;
        end

        for (int j = 0; j < int'(TMO); j++) begin
            rdy = (j == w);
            ec  = mk_ctl(0, is_st & rdy, 0, 0, 0, is_st, is_ld, be, 0, 2'd0);
            if (j == abort_at) begin
                cyc($sformatf("%s.mem%0d", tag, j), rdy, 2'($urandom), ec, 9'd0, 9'd0, 1'b0);
                reset_pulse({tag, ".midmem"});
                return;
            end
            cyc($sformatf("%s.mem%0d", tag, j), rdy, 2'($urandom), ec, 9'd0, 9'd0, 1'b1);
            if (rdy) break;
            if (j == int'(TMO) - 1) begin
                trap_seq(tag, 2'd3);
                return;
            end
        end
        if (is_ld) begin
            cyc({tag, ".wb"}, 1'($urandom), 2'($urandom), mk_ctl(0, 1, 1, 0, 0, 0, 0, 4'b0, 0, 2'd0),
                9'd1, 9'b000000111, 1'b1);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        instr     = 32'd0;
        addr_low  = 2'd0;
        bus_ready = 1'b0;
        #2;
        reset_pulse("init");

        run_instr(32'h002081B3, 2'd0, 0, -1, "add");
        run_instr(32'h402081B3, 2'd0, 0, -1, "sub");
        run_instr(32'h4030D093, 2'd0, 0, -1, "srai");
        run_instr(32'h40008093, 2'd0, 0, -1, "addi_b30");
        run_instr(32'h0020A023, 2'd0, 3, -1, "sw_w3");
        run_instr(32'h00008183, 2'd2, 0, -1, "lb_a2");
        run_instr(32'h00209023, 2'd1, 0, -1, "sh_mis");
        run_instr(32'h00000000, 2'd0, 0, -1, "op0");
        run_instr(32'h0000A183, 2'd0, 100, -1, "lw_tmo");
        run_instr(32'h0000A183, 2'd0, 15, -1, "lw_w15");
        run_instr(32'h0000A183, 2'd0, 5, 2, "lw_rst");

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ins;
            int          w;
            int          ab;
            ins = rand_instr();
            w   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(13, 20));
            ab  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_instr(ins, 2'($urandom), w, ab, $sformatf("r%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
